// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed driver for a shared 4-digit seven-segment bus. Each digit
// is strobed for SCAN_CNT cycles, followed by BLANK_CNT dark cycles, to stop
// ghosting. New content is staged in a pending set and moved to the shadow
// set only at the frame boundary, so a frame never mixes old and new values.
module seg7_scan_ctrl #(
  parameter int SCAN_CNT  = 50000,
  parameter int BLANK_CNT = 500
) (
  input  logic        FPGA_CLK,
  input  logic        RESET_BUT,
  input  logic [15:0] data,
  input  logic [3:0]  dots,
  input  logic [3:0]  en_mask,
  input  logic        lz_blank,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [6:0]  segment,
  output logic        dot_n,
  output logic [3:0]  dig_n
);

  localparam int MAX_CNT = (SCAN_CNT > BLANK_CNT) ? SCAN_CNT : BLANK_CNT;
  localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_CNT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CNT - 1);

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_BLANK  = 1'b1
  } state_t;

  // Active-low hex decode, bit order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every higher nibble are zero.
  // Digit 0 is always shown so a value of zero still reads "0".
  function automatic logic is_leading_zero(input logic [15:0] d, input logic [1:0] idx);
    logic z;
    case (idx)
      2'd3:    z = (d[15:12] == 4'h0);
      2'd2:    z = (d[15:8]  == 8'h00);
      2'd1:    z = (d[15:4]  == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  // Scan FSM position
  state_t          state_p0, state_nx;
  logic [1:0]      idx_p0, idx_nx;
  logic [CW-1:0]   cnt_p0, cnt_nx;
  logic            boundary;

  // Pending (staged) set
  logic [15:0]     pd_data;
  logic [3:0]      pd_dots;
  logic [3:0]      pd_mask;
  logic            pd_lz;
  logic            pend;

  // Shadow (displayed) set
  logic [15:0]     sh_data;
  logic [3:0]      sh_dots;
  logic [3:0]      sh_mask;
  logic            sh_lz;
  logic            ack_p0;

  // Output-stage combinational view of the current position
  logic [3:0]      nib;
  logic            lit;

  // FSM state register: reset parks the scan at the start of digit 0.
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      state_p0 <= ST_ACTIVE;
      idx_p0   <= 2'd0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nx;
      idx_p0   <= idx_nx;
      cnt_p0   <= cnt_nx;
    end
  end

  // Next-state: ACTIVE(idx) for SCAN_CNT cycles, BLANK(idx) for BLANK_CNT,
  // then the next digit; leaving BLANK(3) is the frame boundary.
  always_comb begin
    state_nx = state_p0;
    idx_nx   = idx_p0;
    cnt_nx   = cnt_p0 + CW'(1);
    boundary = 1'b0;
    case (state_p0)
      ST_ACTIVE: begin
        if (cnt_p0 == SCAN_LAST) begin
          state_nx = ST_BLANK;
          cnt_nx   = '0;
        end
      end
      default: begin
        if (cnt_p0 == BLANK_LAST) begin
          state_nx = ST_ACTIVE;
          idx_nx   = idx_p0 + 2'd1;
          cnt_nx   = '0;
          boundary = (idx_p0 == 2'd3);
        end
      end
    endcase
  end

  // Pending data capture: last load wins, no reset needed since pend gates it.
  always_ff @(posedge FPGA_CLK) begin
    if (load) begin
      pd_data <= data;
      pd_dots <= dots;
      pd_mask <= en_mask;
      pd_lz   <= lz_blank;
    end
  end

  // Pending flag: set by load, cleared at every boundary (a load on the
  // boundary cycle bypasses straight into the shadow set instead).
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      pend <= 1'b0;
    end else if (boundary) begin
      pend <= 1'b0;
    end else if (load) begin
      pend <= 1'b1;
    end
  end

  // Shadow update at the frame boundary, with one ack flag per boundary.
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      sh_data <= 16'h0000;
      sh_dots <= 4'h0;
      sh_mask <= 4'hF;
      sh_lz   <= 1'b0;
      ack_p0  <= 1'b0;
    end else begin
      ack_p0 <= 1'b0;
      if (boundary) begin
        if (load) begin
          sh_data <= data;
          sh_dots <= dots;
          sh_mask <= en_mask;
          sh_lz   <= lz_blank;
          ack_p0  <= 1'b1;
        end else if (pend) begin
          sh_data <= pd_data;
          sh_dots <= pd_dots;
          sh_mask <= pd_mask;
          sh_lz   <= pd_lz;
          ack_p0  <= 1'b1;
        end
      end
    end
  end

  // ---- output stage: registered pins derived from the current position ----

  // Select the nibble of the digit being scanned and decide if it lights.
  always_comb begin
    nib = sh_data[{idx_p0, 2'b00} +: 4];
    lit = (state_p0 == ST_ACTIVE) && sh_mask[idx_p0]
          && !(sh_lz && is_leading_zero(sh_data, idx_p0));
  end

  // Output registers: all pins dark and pulses low while in reset.
  always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      dig_n      <= 4'hF;
      segment    <= 7'h7F;
      dot_n      <= 1'b1;
      frame_tick <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      dig_n      <= lit ? ~(4'b0001 << idx_p0) : 4'hF;
      segment    <= lit ? seg_decode(nib) : 7'h7F;
      dot_n      <= lit ? ~sh_dots[idx_p0] : 1'b1;
      frame_tick <= (state_p0 == ST_ACTIVE) && (idx_p0 == 2'd0) && (cnt_p0 == '0);
      load_ack   <= ack_p0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: a time-based behavioural model of the scan
// schedule and register sets, a per-cycle output compare, and literal checks.
module tb_seg7_scan_ctrl;

  localparam int SCAN  = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = SCAN + BLANK;
  localparam int FRAME = 4 * SLOT;

  logic        FPGA_CLK  = 1'b0;
  logic        RESET_BUT = 1'b0;
  logic [15:0] data      = 16'h0;
  logic [3:0]  dots      = 4'h0;
  logic [3:0]  en_mask   = 4'hF;
  logic        lz_blank  = 1'b0;
  logic        load      = 1'b0;
  logic        load_ack;
  logic        frame_tick;
  logic [6:0]  segment;
  logic        dot_n;
  logic [3:0]  dig_n;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_ctrl #(.SCAN_CNT(SCAN), .BLANK_CNT(BLANK)) dut (
    .FPGA_CLK  (FPGA_CLK),
    .RESET_BUT (RESET_BUT),
    .data      (data),
    .dots      (dots),
    .en_mask   (en_mask),
    .lz_blank  (lz_blank),
    .load      (load),
    .load_ack  (load_ack),
    .frame_tick(frame_tick),
    .segment   (segment),
    .dot_n     (dot_n),
    .dig_n     (dig_n)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] dec [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                           7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  int          m_k;          // edges since reset release
  logic [15:0] m_sd;  logic [3:0] m_sdt, m_sm;  logic m_slz;
  logic [15:0] m_pd;  logic [3:0] m_pdt, m_pm;  logic m_plz;
  logic        m_pend, m_ack_next;
  logic [3:0]  e_dig = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dot = 1'b1, e_ft = 1'b0, e_ack = 1'b0;

  task automatic model_reset();
    m_k = 0;
    m_sd = 16'h0; m_sdt = 4'h0; m_sm = 4'hF; m_slz = 1'b0;
    m_pend = 1'b0; m_ack_next = 1'b0;
    e_dig = 4'hF; e_seg = 7'h7F; e_dot = 1'b1; e_ft = 1'b0; e_ack = 1'b0;
  endtask

  always @(posedge FPGA_CLK or negedge RESET_BUT) begin
    if (!RESET_BUT) begin
      model_reset();
    end else begin
      int p, d;
      logic [3:0] n;
      logic on;
      p  = m_k % FRAME;
      d  = p / SLOT;
      n  = 4'((m_sd >> (4 * d)) & 16'hF);
      on = ((p % SLOT) < SCAN) && m_sm[d]
           && !(m_slz && d != 0 && (m_sd >> (4 * d)) == 16'h0);
      e_dig = on ? ~(4'b0001 << d) : 4'hF;
      e_seg = on ? dec[n] : 7'h7F;
      e_dot = on ? ~m_sdt[d] : 1'b1;
      e_ft  = (p == 0);
      e_ack = m_ack_next;
      m_ack_next = 1'b0;
      if (load) begin
        if (p == FRAME - 1) begin
          m_sd = data; m_sdt = dots; m_sm = en_mask; m_slz = lz_blank;
          m_pend = 1'b0; m_ack_next = 1'b1;
        end else begin
          m_pd = data; m_pdt = dots; m_pm = en_mask; m_plz = lz_blank;
          m_pend = 1'b1;
        end
      end else if (p == FRAME - 1 && m_pend) begin
        m_sd = m_pd; m_sdt = m_pdt; m_sm = m_pm; m_slz = m_plz;
        m_pend = 1'b0; m_ack_next = 1'b1;
      end
      m_k++;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge FPGA_CLK) begin
    chk("cycle {ack,tick,dig_n,segment,dot_n}",
        {2'b00, load_ack, frame_tick, dig_n, segment, dot_n},
        {2'b00, e_ack, e_ft, e_dig, e_seg, e_dot});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge FPGA_CLK);
  endtask

  task automatic wait_frame();
    logic found;
    found = 1'b0;
    for (int i = 0; i < FRAME + 8 && !found; i++) begin
      @(negedge FPGA_CLK);
      if (frame_tick === 1'b1) found = 1'b1;
    end
    if (!found) chk("frame_tick timeout", 16'd0, 16'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dt,
                         input logic [3:0] m, input logic lz);
    data = d; dots = dt; en_mask = m; lz_blank = lz; load = 1'b1;
    @(negedge FPGA_CLK);
    load = 1'b0;
    data = 16'($urandom); dots = 4'($urandom); en_mask = 4'($urandom); lz_blank = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset hold with activity on the inputs.
    load = 1'b1; data = 16'h9876;
    step(3);
    chk("reset dig_n", {12'h0, dig_n}, 16'h000F);
    chk("reset segment", {9'h0, segment}, 16'h007F);
    chk("reset dot_n/ack/tick", {13'h0, dot_n, load_ack, frame_tick}, 16'h0004);
    load = 1'b0;
    #2 RESET_BUT = 1'b1;

    // First frame shows 0000.
    wait_frame();
    chk("first frame dig_n", {12'h0, dig_n}, 16'h000E);
    chk("first frame segment", {9'h0, segment}, 16'h0001);

    // Atomic update mid-frame.
    step(5);
    do_load(16'h1234, 4'h0, 4'hF, 1'b0);
    wait_frame();
    chk("atomic ack", {15'h0, load_ack}, 16'h0001);
    chk("atomic d0", {5'h0, dig_n, segment}, {5'h0, 4'b1110, 7'h4C});
    step(SLOT);
    chk("atomic d1", {5'h0, dig_n, segment}, {5'h0, 4'b1101, 7'h06});
    step(SLOT);
    chk("atomic d2", {5'h0, dig_n, segment}, {5'h0, 4'b1011, 7'h12});
    step(SLOT);
    chk("atomic d3", {5'h0, dig_n, segment}, {5'h0, 4'b0111, 7'h4F});

    // Overwrite: two loads in one frame, one ack.
    wait_frame();
    step(3);
    do_load(16'hAAAA, 4'h0, 4'hF, 1'b0);
    step(4);
    do_load(16'h5555, 4'h0, 4'hF, 1'b0);
    wait_frame();
    chk("overwrite ack", {15'h0, load_ack}, 16'h0001);
    chk("overwrite seg", {9'h0, segment}, 16'h0024);

    // Bypass: load sampled on the boundary edge.
    step(FRAME - 2);
    do_load(16'h89AB, 4'h0, 4'hF, 1'b0);
    step(1);
    chk("bypass ack+tick", {14'h0, load_ack, frame_tick}, 16'h0003);
    chk("bypass seg", {9'h0, segment}, 16'h0060);

    // Leading-zero suppression and dot.
    do_load(16'h0050, 4'b0010, 4'hF, 1'b1);
    wait_frame();
    chk("lz d0", {4'h0, dig_n, segment, dot_n}, {4'h0, 4'b1110, 7'h01, 1'b1});
    step(SLOT);
    chk("lz d1", {4'h0, dig_n, segment, dot_n}, {4'h0, 4'b1101, 7'h24, 1'b0});
    step(SLOT);
    chk("lz d2 dark", {4'h0, dig_n, segment, dot_n}, {4'h0, 4'hF, 7'h7F, 1'b1});
    step(SLOT);
    chk("lz d3 dark", {12'h0, dig_n}, 16'h000F);

    // Mask 0101 without suppression.
    do_load(16'h0050, 4'b0010, 4'b0101, 1'b0);
    wait_frame();
    chk("mask d0", {12'h0, dig_n}, 16'h000E);
    step(SLOT);
    chk("mask d1 dark", {12'h0, dig_n}, 16'h000F);
    step(SLOT);
    chk("mask d2", {5'h0, dig_n, segment}, {5'h0, 4'b1011, 7'h01});

    // Randomised loads, checked every cycle by the compare process.
    for (int i = 0; i < 800; i++) begin
      data = 16'($urandom); dots = 4'($urandom);
      en_mask = 4'($urandom); lz_blank = 1'($urandom);
      load = ($urandom_range(0, 9) == 0);
      @(negedge FPGA_CLK);
    end
    load = 1'b0;

    // Reset mid-scan with a pending load.
    do_load(16'h7777, 4'h0, 4'hF, 1'b0);
    wait_frame();
    step(1);
    do_load(16'hBEEF, 4'hF, 4'hF, 1'b0);
    step(10);
    chk("pre-reset d2", {5'h0, dig_n, segment}, {5'h0, 4'b1011, 7'h0F});
    #2 RESET_BUT = 1'b0;
    #1;
    chk("async reset outputs", {2'h0, load_ack, frame_tick, dig_n, segment, dot_n},
        {2'h0, 1'b0, 1'b0, 4'hF, 7'h7F, 1'b1});
    step(3);
    #2 RESET_BUT = 1'b1;
    wait_frame();
    chk("post-reset no ack", {15'h0, load_ack}, 16'h0000);
    chk("post-reset d0", {5'h0, dig_n, segment}, {5'h0, 4'b1110, 7'h01});
    step(FRAME);
    chk("pending lost", {8'h0, load_ack, segment}, {8'h0, 1'b0, 7'h01});

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
